mio_responder: RTL

- Bus-side responder for the multicycle CPU's memory/IO request interface. It accepts MemRead/MemWrite requests qualified by CPU_MIO, decodes the address, and runs the access either to the synchronous block RAM or to the peripheral bus.
- It returns read data and a single-cycle MIO_ready pulse, which is what releases the CPU control FSM from its wait states.
- It sits between the CPU core and the RAM/peripheral fabric.

---
 rtl/mio_responder.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mio_responder.sv
// Memory/IO request responder: routes CPU word accesses to block RAM or the peripheral bus.
// Optional peripheral ack timeout is enabled with `define MIO_TIMEOUT_EN.
module mio_responder #(
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned RAM_AW  = 12,
    parameter logic [31:0] IO_BASE = 32'hE000_0000,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_we,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [27:0]       io_addr,
    output logic              io_rd,
    output logic              io_wr,
    output logic [31:0]       io_wdata,
    input  logic [31:0]       io_rdata,
    input  logic              io_ack
);

    localparam int unsigned LatW = 4;

    typedef enum logic [1:0] {StIdle, StRamWait, StIoWait, StResp} state_e;

    state_e            state_q, state_d;
    logic [LatW-1:0]   lat_q;
    logic              ram_rd_q;
    logic              err_q;
    logic [31:0]       data_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic              ram_we_q;
    logic [31:0]       ram_din_q;
    logic [27:0]       io_addr_q;
    logic              io_rd_q, io_wr_q;
    logic [31:0]       io_wdata_q;

    logic req_bad, req_io, req_ram;
    logic timeout_hit;
    logic unused_bits;

    assign unused_bits = ^{addr[1:0], 1'(TIMEOUT & 1)};

    always_comb begin
        req_bad = (MemRead == MemWrite);
        req_io  = (addr[31:28] == IO_BASE[31:28]);
        req_ram = ((addr >> (RAM_AW + 2)) == 32'd0);
    end

`ifdef MIO_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [ToW-1:0] to_cnt_q;

    // Counts IO_WAIT cycles; an io_ack on the expiry cycle still wins.
    assign timeout_hit = (state_q == StIoWait) && !io_ack &&
                         (to_cnt_q == ToW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (state_q != StIoWait) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + ToW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (CPU_MIO) begin
                    if (req_bad)      state_d = StResp;
                    else if (req_io)  state_d = StIoWait;
                    else if (req_ram) state_d = StRamWait;
                    else              state_d = StResp;
                end
            end
            StRamWait: begin
                if (lat_q == '0) state_d = StResp;
            end
            StIoWait: begin
                if (io_ack || timeout_hit) state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_q      <= '0;
            ram_rd_q   <= 1'b0;
            err_q      <= 1'b0;
            data_q     <= '0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_din_q  <= '0;
            io_addr_q  <= '0;
            io_rd_q    <= 1'b0;
            io_wr_q    <= 1'b0;
            io_wdata_q <= '0;
        end else begin
            ram_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (CPU_MIO) begin
                        err_q <= 1'b0;
                        if (req_bad || (!req_io && !req_ram)) begin
                            err_q  <= 1'b1;
                            data_q <= '0;
                        end else if (req_io) begin
                            io_addr_q  <= addr[27:0];
                            io_wdata_q <= Data_out;
                            io_rd_q    <= MemRead;
                            io_wr_q    <= MemWrite;
                        end else begin
                            ram_addr_q <= addr[RAM_AW+1:2];
                            ram_din_q  <= Data_out;
                            ram_we_q   <= MemWrite;
                            ram_rd_q   <= MemRead;
                            lat_q      <= LatW'(RAM_LAT - 1);
                        end
                    end
                end
                StRamWait: begin
                    if (lat_q == '0) begin
                        if (ram_rd_q) data_q <= ram_dout;
                    end else begin
                        lat_q <= lat_q - LatW'(1);
                    end
                end
                StIoWait: begin
                    if (io_ack) begin
                        io_rd_q <= 1'b0;
                        io_wr_q <= 1'b0;
                        if (io_rd_q) data_q <= io_rdata;
                    end else if (timeout_hit) begin
                        io_rd_q <= 1'b0;
                        io_wr_q <= 1'b0;
                        data_q  <= 32'hDEAD_BEEF;
                        err_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        MIO_ready = (state_q == StResp);
        bus_err   = (state_q == StResp) && err_q;
        Data_in   = data_q;
        ram_addr  = ram_addr_q;
        ram_we    = ram_we_q;
        ram_din   = ram_din_q;
        io_addr   = io_addr_q;
        io_rd     = io_rd_q;
        io_wr     = io_wr_q;
        io_wdata  = io_wdata_q;
    end

endmodule
